column_event_requester: RTL

//  Requester side of the column arbitration handshake for one pixel row. Latches per-column

---
 rtl/column_event_requester.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/column_event_requester.sv
`default_nettype none
// ============================================================================
// Module      : column_event_requester
// Description : Requester side of the column arbitration handshake for one
//               pixel row. Collects column events into pending bits, requests
//               the row arbiter, then serves a frozen snapshot through the
//               column arbiter and reports completion, timeout and errors.
// Revision    : 1.0 - initial release
// ============================================================================
module column_event_requester #(
    parameter int COLS    = 8,
    parameter int TIMEOUT = 16,
    parameter int DROP_W  = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [COLS-1:0]   event_i,
    output logic              row_req_o,
    input  logic              row_gnt_i,
    output logic              col_enable_o,
    output logic [COLS-1:0]   col_req_o,
    input  logic [COLS-1:0]   col_gnt_i,
    output logic              row_done_o,
    output logic              timeout_o,
    output logic              err_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam int c_tmr_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int c_pop_w = $clog2(COLS + 1);
    localparam int c_sum_w = DROP_W + c_pop_w;
    localparam logic [c_tmr_w-1:0] c_timer_last = c_tmr_w'(TIMEOUT - 1);
    localparam logic [DROP_W-1:0]  c_drop_max   = {DROP_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_SERVE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [COLS-1:0]     r_pend;
    logic [COLS-1:0]     r_active;
    logic [c_tmr_w-1:0]  r_timer;
    logic                r_timeout;
    logic                r_err;
    logic [DROP_W-1:0]   r_drop_cnt;

    logic [COLS-1:0]     w_pend_nxt;
    logic [COLS-1:0]     w_active_nxt;
    logic [c_tmr_w-1:0]  w_timer_nxt;
    logic                w_timeout_nxt;
    logic [COLS-1:0]     w_drop;
    logic [COLS-1:0]     w_clr;
    logic [COLS-1:0]     w_remain;
    logic                w_multi_hot;
    logic                w_illegal;
    logic [c_pop_w-1:0]  w_pop;
    logic [c_sum_w-1:0]  w_sum;
    logic [DROP_W-1:0]   w_drop_nxt;

    // Grant bits that legally retire snapshot columns, and what is left afterwards
    assign w_clr       = col_gnt_i & r_active;
    assign w_remain    = r_active & ~col_gnt_i;
    assign w_multi_hot = (col_gnt_i & (col_gnt_i - COLS'(1))) != '0;
    assign w_illegal   = (col_gnt_i != '0) &&
                         (w_multi_hot || (r_state != S_SERVE) || ((col_gnt_i & ~r_active) != '0));

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update decode
    always_comb begin
        w_state_nxt   = r_state;
        w_pend_nxt    = r_pend | event_i;
        w_active_nxt  = r_active;
        w_timer_nxt   = r_timer;
        w_timeout_nxt = 1'b0;
        w_drop        = event_i & r_pend;
        case (r_state)
            S_IDLE: begin
                if (r_pend != '0) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (row_gnt_i) begin
                    // Pending bits move into the snapshot, so same-cycle events are not lost
                    w_active_nxt = r_pend;
                    w_pend_nxt   = event_i;
                    w_drop       = '0;
                    w_timer_nxt  = '0;
                    w_state_nxt  = S_SERVE;
                end
            end
            S_SERVE: begin
                w_active_nxt = w_remain;
                if (w_remain == '0) begin
                    w_state_nxt = S_DONE;
                end else if (w_clr != '0) begin
                    w_timer_nxt = '0;
                end else if (r_timer == c_timer_last) begin
                    // Abort: unserved columns fold back into pending for a later retry
                    w_pend_nxt    = r_pend | r_active | event_i;
                    w_active_nxt  = '0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + c_tmr_w'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Saturating accumulation of events lost on already-pending bits
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < COLS; i++) begin
            w_pop = w_pop + c_pop_w'(w_drop[i]);
        end
        w_sum = c_sum_w'(r_drop_cnt) + c_sum_w'(w_pop);
        if (w_sum > c_sum_w'(c_drop_max)) begin
            w_drop_nxt = c_drop_max;
        end else begin
            w_drop_nxt = w_sum[DROP_W-1:0];
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pend     <= '0;
            r_active   <= '0;
            r_timer    <= '0;
            r_timeout  <= 1'b0;
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_active   <= w_active_nxt;
            r_timer    <= w_timer_nxt;
            r_timeout  <= w_timeout_nxt;
            r_err      <= r_err | w_illegal;
            r_drop_cnt <= w_drop_nxt;
        end
    end

    // Outputs decoded from state and registers only
    assign row_req_o    = (r_state == S_REQ);
    assign col_enable_o = (r_state == S_SERVE);
    assign col_req_o    = (r_state == S_SERVE) ? r_active : '0;
    assign row_done_o   = (r_state == S_DONE);
    assign timeout_o    = r_timeout;
    assign err_o        = r_err;
    assign drop_cnt_o   = r_drop_cnt;

endmodule
`default_nettype wire
